multicycle_control: RTL and testbench

- Sequencing FSM that converts the RV64I datapath into a multi-cycle machine sharing one memory port between instruction fetch and data access.
- Decodes opcode[6:0] into per-cycle strobes for PC, instruction register, register file, ALU muxes and memory.
- Handshakes with memory through mem_req/mem_ready.
- Counts retired instructions for the test harness.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_control_retire_counter.sv | 20 ++
 rtl/multicycle_control.sv | 141 ++++++++++++++
 tb/tb_multicycle_control.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and state encoding for the multi-cycle RV64I control path.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WRITE = 4'd6,
        WB_MEM    = 4'd7,
        WB_ALU    = 4'd8,
        BRANCH    = 4'd9
    } ctrl_state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
               (op == OP_SD) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory-port handshake between the control FSM and the memory.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: synchronous clear, increment on enable, free wrap.
module retire_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COUNT_W-1:0] count_o
);
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr_i)
            count_q <= '0;
        else if (en_i)
            count_q <= count_q + 1'b1;
    end

    assign count_o = count_q;
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: one memory port shared by fetch and data access,
// per-state strobes for the RV64I datapath, retired-instruction count.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 retire,
    output logic                 illegal,
    output logic [COUNT_W-1:0]   instr_count,
    output logic [3:0]           state_dbg
);
    ctrl_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    // Strobes are held at zero while reset is high so a pending request is
    // dropped immediately rather than waiting for mem_ready.
    always_comb begin
        state_d     = FETCH;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.i_or_d  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALUOP_ADD;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem.mem_req = 1'b1;
                    alu_src_b   = SRCB_FOUR;
                    ir_write    = mem.mem_ready;
                    pc_write    = mem.mem_ready;
                    state_d     = mem.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_R:         state_d = EXEC_R;
                        OP_I:         state_d = EXEC_I;
                        OP_LD, OP_SD: state_d = MEM_ADDR;
                        OP_BEQ:       state_d = BRANCH;
                        default: begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_op    = ALUOP_FUNCT;
                    state_d   = WB_ALU;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                    state_d   = WB_ALU;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_LD)
                        state_d = MEM_READ;
                    else if (opcode == OP_SD)
                        state_d = MEM_WRITE;
                    else
                        state_d = FETCH;
                end
                MEM_READ: begin
                    mem.mem_req = 1'b1;
                    mem.i_or_d  = 1'b1;
                    state_d     = mem.mem_ready ? WB_MEM : MEM_READ;
                end
                MEM_WRITE: begin
                    mem.mem_req = 1'b1;
                    mem.i_or_d  = 1'b1;
                    mem.mem_we  = 1'b1;
                    retire      = mem.mem_ready;
                    state_d     = mem.mem_ready ? FETCH : MEM_WRITE;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_op    = ALUOP_SUB;
                    pc_source = 1'b1;
                    pc_write  = zero;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    retire_counter #(.COUNT_W(COUNT_W)) u_retire_counter (
        .clk     (clk),
        .clr_i   (reset),
        .en_i    (retire),
        .count_o (instr_count)
    );

    assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction latency, strobe
// counts and retire count checked against a table-driven instruction model.
module tb_multicycle_control;
    import riscv_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          zero;
    logic          ir_write, pc_write, pc_source, alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic          mem_to_reg, reg_write, retire, illegal;
    logic [CW-1:0] instr_count;
    logic [3:0]    state_dbg;
    logic [14:0]   strobes;

    multicycle_control_if mif();

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem         (mif),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_source   (pc_source),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .retire      (retire),
        .illegal     (illegal),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    assign strobes = {mif.mem_req, mif.mem_we, mif.i_or_d, ir_write, pc_write, pc_source,
                      alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write, retire, illegal};

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] cnt_m;
    ctrl_state_t   trace[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from FETCH; wf/wd are wait cycles on the fetch and
    // data accesses. Expectations come from the instruction class alone.
    task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wd);
        int cyc, n_ret, n_ill, n_rw, n_we, n_rd, n_if, n_pcw, n_pcs, n_mtr, lat, wfl, wdl;
        bit done, legal, is_ld, is_sd, is_beq;
        cyc = 0; n_ret = 0; n_ill = 0; n_rw = 0; n_we = 0; n_rd = 0; n_if = 0;
        n_pcw = 0; n_pcs = 0; n_mtr = 0; wfl = wf; wdl = wd; done = 0;
        opcode = op;
        zero   = z;
        trace.delete();
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (mif.mem_req) begin
                if (mif.i_or_d) begin
                    mif.mem_ready = (wdl == 0);
                    if (wdl > 0) wdl--;
                end else begin
                    mif.mem_ready = (wfl == 0);
                    if (wfl > 0) wfl--;
                end
            end else begin
                mif.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            trace.push_back(ctrl_state_t'(state_dbg));
            n_ret += int'(retire);
            n_ill += int'(illegal);
            n_rw  += int'(reg_write);
            n_mtr += int'(reg_write & mem_to_reg);
            n_we  += int'(mif.mem_req & mif.mem_we);
            n_rd  += int'(mif.mem_req & mif.i_or_d & ~mif.mem_we);
            n_if  += int'(mif.mem_req & ~mif.i_or_d);
            n_pcw += int'(pc_write);
            n_pcs += int'(pc_write & pc_source);
            cyc++;
            done = retire | illegal;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        legal  = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
        is_ld  = (op == OP_LD);
        is_sd  = (op == OP_SD);
        is_beq = (op == OP_BEQ);
        lat = !legal ? 2 : is_beq ? 3 : is_ld ? 5 : 4;
        lat += wf + ((is_ld || is_sd) ? wd : 0);
        chk("latency",   cyc,   lat);
        chk("retire",    n_ret, legal ? 1 : 0);
        chk("illegal",   n_ill, legal ? 0 : 1);
        chk("reg_write", n_rw,  (op == OP_R || op == OP_I || is_ld) ? 1 : 0);
        chk("mem_to_rg", n_mtr, is_ld ? 1 : 0);
        chk("fetch_req", n_if,  wf + 1);
        chk("rd_req",    n_rd,  is_ld ? wd + 1 : 0);
        chk("wr_req",    n_we,  is_sd ? wd + 1 : 0);
        chk("pc_write",  n_pcw, 1 + ((is_beq && z) ? 1 : 0));
        chk("pc_src",    n_pcs, (is_beq && z) ? 1 : 0);
        if (legal) cnt_m = cnt_m + 1'b1;
        @(posedge clk);
        #1;
        chk("end_state", state_dbg, FETCH);
        chk("count",     instr_count, cnt_m);
    endtask

    initial begin
        bit hit;
        logic [6:0] op;
        reset = 1'b1;
        opcode = 7'd0;
        zero = 1'b0;
        mif.mem_ready = 1'b0;
        cnt_m = '0;

        // Reset: strobes gated even if mem_ready rises.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mif.mem_ready = (i == 1);
            #1;
            chk("rst_strobes", strobes, 15'd0);
            chk("rst_count",   instr_count, 0);
        end
        reset = 1'b0;
        mif.mem_ready = 1'b0;
        #1;
        chk("rel_state",  state_dbg, FETCH);
        chk("rel_req",    mif.mem_req, 1'b1);
        chk("rel_i_or_d", mif.i_or_d, 1'b0);

        // R-type, zero wait
        run_instr(OP_R, 1'b0, 0, 0);
        chk("r_len", trace.size(), 4);
        if (trace.size() == 4) begin
            chk("r_s0", trace[0], FETCH);
            chk("r_s1", trace[1], DECODE);
            chk("r_s2", trace[2], EXEC_R);
            chk("r_s3", trace[3], WB_ALU);
        end

        // ld with three wait cycles on the data read
        run_instr(OP_LD, 1'b0, 0, 3);
        if (trace.size() == 8) begin
            for (int i = 3; i < 7; i++) chk("ld_wait", trace[i], MEM_READ);
            chk("ld_wb", trace[7], WB_MEM);
        end

        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 1, 0);
        run_instr(7'h7F, 1'b0, 0, 0);
        run_instr(OP_SD, 1'b0, 2, 1);

        // Reset in the middle of a stalled store
        opcode = OP_SD;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (state_dbg == MEM_WRITE) begin
                mif.mem_ready = 1'b0;
                reset = 1'b1;
                hit = 1;
            end else begin
                mif.mem_ready = 1'b1;
            end
        end
        if (!hit) chk("mw_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("mr_state",   state_dbg, FETCH);
        chk("mr_strobes", strobes, 15'd0);
        chk("mr_count",   instr_count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_we",  mif.mem_we, 1'b0);
        chk("mr_req", mif.mem_req, 1'b1);
        cnt_m = '0;

        // Fill the counter to all-ones, then retire once more to wrap
        for (int i = 0; i < (1 << CW) - 1; i++)
            run_instr(OP_I, 1'b0, $urandom_range(0, 1), 0);
        chk("cnt_full", instr_count, (1 << CW) - 1);
        run_instr(OP_R, 1'b0, 0, 0);
        chk("cnt_wrap", instr_count, 0);

        // Random instruction mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_SD;
                4: op = OP_BEQ;
                default: op = 7'($urandom);
            endcase
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
